// File: rtl/skew_pkg.sv
// Shared constants and the lane-delay rule for the skew/deskew register bank.
package skew_pkg;

    typedef enum int {
        DIR_SKEW   = 0,
        DIR_DESKEW = 1
    } dir_e;

    localparam int W_DEFAULT     = 18;
    localparam int LANES_DEFAULT = 4;
    localparam int BASE_DEFAULT  = 1;
    localparam int MAX_DELAY     = BASE_DEFAULT + LANES_DEFAULT - 1;

    // Skew gives the highest lane the longest chain; deskew mirrors it.
    function automatic int lane_delay(input int k, input int base, input int lanes, input int dir);
        return (dir == DIR_DESKEW) ? (base + lanes - 1 - k) : (base + k);
    endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane: a DEPTH-stage {valid, data} shift chain with stall, flush and zero-insertion.
module delay_lane #(
    parameter int W     = 18,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         busy
);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][W-1:0]  data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
            data_d  = '0;
        end else if (en) begin
            // Invalid words enter as zero so the array downstream sees clean padding.
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every stage is reset, data included, because outputs must read zero during reset.
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking so all stages shift on the old values of their neighbours.
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign busy      = |valid_q;

endmodule

// File: rtl/skew_delay_line.sv
// Multi-lane skew (DIR=0) or deskew (DIR=1) register bank feeding/draining a systolic array.
module skew_delay_line
    import skew_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int LANES = LANES_DEFAULT,
    parameter int BASE  = BASE_DEFAULT,
    parameter int DIR   = DIR_SKEW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [LANES*W-1:0] in_data,
    output logic [LANES-1:0]   out_valid,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES*W-1:0] out_data_n,
    output logic               busy
);

    logic [LANES-1:0] lane_busy;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        delay_lane #(
            .W     (W),
            .DEPTH (lane_delay(k, BASE, LANES, DIR))
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_data   (in_data[k*W +: W]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*W +: W]),
            .busy      (lane_busy[k])
        );
    end

    assign out_data_n = ~out_data;
    assign busy       = |lane_busy;

endmodule

// File: doc/skew_delay_line.md
Name: skew_delay_line

Overview:
- Multi-lane, parametrised pipeline register bank that generalises the single-stage D flip-flop register.
- Lane k delays its W-bit word by a lane-dependent number of enabled cycles.
- Used to skew operand rows/columns into the systolic matrix-multiplication array (DIR=0), or to deskew result lanes coming out of it (DIR=1).
- Adds stall, flush, valid tracking and zero-insertion, none of which the plain register provides.

Parameters:
- W, 18, data width per lane in bits (>=1).
- LANES, 4, number of lanes (>=1).
- BASE, 1, delay of the shortest lane in enabled cycles (>=1).
- DIR, 0, 0: lane k delay = BASE+k (skew). 1: lane k delay = BASE+LANES-1-k (deskew).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  shift enable. 0 = hold all stages (stall).
- flush  input  1  synchronous clear of all pipeline contents.
- in_valid  input  1  input word set is valid this cycle.
- in_data  input  LANES*W  lane k input at bits [k*W +: W].
- out_valid  output  LANES  per-lane valid at the lane's final stage.
- out_data  output  LANES*W  lane k output at bits [k*W +: W].
- out_data_n  output  LANES*W  bitwise inverse of out_data.
- busy  output  1  OR of every stage valid bit in all lanes.

Behaviour:
- Each lane k is a shift chain of D_k stages, each stage holding {valid, W-bit data}. D_k is set by DIR as in Parameters.
- Reset (rst=0, asynchronous, any time including mid-flight):
  - All stages clear: data=0, valid=0.
  - Outputs immediately read out_data=0, out_valid=0, out_data_n=all ones, busy=0.
  - Release is synchronous to clk. The first input is accepted on the first edge with rst=1.
- en=1, flush=0 at a rising edge:
  - Every stage loads its predecessor.
  - Stage 0 of lane k loads {in_valid, in_valid ? in_data[k] : 0}.
  - Zero-insertion: invalid inputs enter as 0, so downstream MACs see zero padding.
- en=0, flush=0: all stages hold. Inputs presented that cycle are ignored.
- flush=1: all stages clear to valid=0, data=0 at the edge, regardless of en.
  - flush and en together: flush wins and that cycle's input is dropped.
- Latency:
  - A word accepted at edge t appears at lane k's outputs after D_k enabled edges.
  - Stall cycles extend latency one for one.
  - Outputs are registered (last stage). No combinational path from inputs to outputs.
- out_valid[k] equals the last-stage valid bit of lane k.
- out_data_n is combinationally ~out_data.
- busy: combinational OR of all stage valid bits. Deasserts the cycle after the last valid word leaves the final stage, or after a flush.
- Back-to-back valid inputs sustain throughput of one word set per enabled cycle. No bubbles are inserted.
- Width rules: no arithmetic. Data passes bit-exact. Total registers = sum over k of D_k*(W+1).

Decomposition:
- Shared package skew_pkg holds:
  - function lane_delay(k, BASE, LANES, DIR) returning D_k.
  - localparam MAX_DELAY = BASE+LANES-1.
- One sub-module: delay_lane (parameters W, DEPTH). A single valid+data shift chain with en/flush/async reset.
- Top instantiates LANES copies in a generate loop with DEPTH=lane_delay(k).

Test Plan:
- Reset mid-flight: W=18, LANES=4. Load 3 valid word sets, then pulse rst=0 between edges -> out_data=0, out_valid=0, out_data_n=0x3FFFF per lane, busy=0 immediately. The first accepted word after release emerges at normal latency.
- Skew latency: DIR=0, BASE=1. One valid pulse with lanes {0x1,0x2,0x3,0x4} -> lane0 shows 0x1 valid after edge 1, lane1 shows 0x2 after edge 2, lane2 after edge 3, lane3 shows 0x4 after edge 4. Each is valid for exactly one cycle.
- Stall: same pulse, en=0 for 3 cycles after edge 2 -> outputs frozen during the stall. lane3 appears after edge 7, with no duplication or loss.
- Zero-insertion: in_valid=0 with in_data all 0x3FFFF for 6 cycles -> out_data stays 0, out_valid stays 0, busy stays 0.
- Flush priority: stream 4 valid sets, then assert flush=1 and en=1 with a valid input -> next cycle all out_valid=0, busy=0, and that input never emerges. A following valid set has normal latency.
- Deskew: DIR=1, BASE=1, LANES=4. Feed lane k its word at cycle k -> all four lanes present valid data in the same cycle (cycle 4).
